uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Serial receiver at the far end of the UART link driven by the transmit stage.
//   Frame is 11 bits (start, 8 data LSB-first, parity, stop). Each frame is
//   oversampled, then checked for parity and framing, and the byte is handed
//   downstream on a valid/ready register.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per serial bit; must be even and >= 4
//   DATA_BITS     8   payload bits per frame
//   PARITY_ODD    0   0 = even parity (parity bit = ^data); 1 = odd parity
// PORTS
//   clk         in   1          system clock; all logic on posedge
//   rst         in   1          asynchronous, active-high reset
//   rx          in   1          serial line; asynchronous to clk; idles high
//   ready       in   1          downstream accepts data this cycle when valid=1
//   data        out  DATA_BITS  received byte; stable while valid=1
//   valid       out  1          byte held in the output register
//   parity_err  out  1          1-cycle pulse: parity mismatch; byte dropped
//   frame_err   out  1          1-cycle pulse: stop bit sampled low; byte dropped
//   overrun     out  1          1-cycle pulse: new byte lost because valid=1 and ready=0
//   busy        out  1          FSM not in IDLE
// BEHAVIOUR
// - Reset values: data=0, valid=0, all error pulses=0, busy=0, FSM=IDLE,
//   synchroniser flops=1, armed=0. Reset mid-frame aborts the frame silently.
// - rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
// - armed sets on the first rx_s=1 seen in IDLE. A start bit is accepted only
//   when armed=1, so a line held low through reset is not taken as a start bit.
// - FSM states and transitions:
//   IDLE   : armed and rx_s=0 -> START, bit counter (cnt) = 0.
//   START  : at cnt = CLKS_PER_BIT/2-1, re-sample. rx_s=1 -> IDLE (glitch reject).
//            rx_s=0 -> DATA, cnt=0, bit index=0.
//   DATA   : sample at cnt = CLKS_PER_BIT-1 (mid-bit) into shift reg, LSB first.
//            After bit DATA_BITS-1 -> PARITY.
//   PARITY : sample one bit and compare with ^shift ^ PARITY_ODD -> STOP.
//   STOP   : sample one bit.
//            rx_s=0 -> frame_err, then BREAK.
//            Parity mismatch -> parity_err, then IDLE.
//            Otherwise deliver the byte, then IDLE.
//            Framing takes priority: when both errors occur, only frame_err pulses.
//   BREAK  : wait for rx_s=1 -> IDLE.
// - Delivery happens in the cycle after the stop-bit sample.
//   - Output register free (valid=0, or valid=1 and ready=1 this cycle):
//     data <= shift, valid <= 1.
//   - Otherwise: overrun pulses, the old data/valid are kept, the new byte is dropped.
// - valid clears on a valid & ready cycle unless a new byte loads in that same
//   cycle (that case is not an overrun).
// - Latency: rx falling edge to valid rising is 2 synchroniser cycles plus
//   CLKS_PER_BIT/2 plus (DATA_BITS+2)*CLKS_PER_BIT plus 1 cycle.
// - cnt width is $clog2(CLKS_PER_BIT). cnt wraps to 0 on every sample;
//   no free-running baud tick.
// - ready is ignored while valid=0. Error pulses never coincide with a valid rise.
// STRUCTURE
// - uart_pkg (shared with the transmit stage): state encoding localparams, the
//   frame length constant (DATA_BITS+3 = 11), and a parity function.
// - One sub-module, sync_2ff: 2-flop synchroniser with reset value parameter
//   (set to 1 here); reused by other async inputs.
// - The FSM, counters, shift register and output register all live in uart_rx.
// TESTING  (CLKS_PER_BIT=16, DATA_BITS=8, PARITY_ODD=0, ready=1 unless stated)
// 1. Send frame 0xA5, parity 0, stop 1 -> valid for 1 cycle, data=0xA5,
//    no error pulses; latency matches the formula above.
// 2. Pulse rx low for 5 cycles, then high -> no START acceptance past the
//    mid-bit check; busy returns to 0; valid, frame_err, parity_err stay 0.
// 3. Send 0x3C with parity bit 1 -> parity_err pulses once; valid stays 0.
//    Send 0x3C with stop bit 0 -> frame_err only. Hold rx low 40 bits, then
//    send 0x01 -> data=0x01.
// 4. With ready=0, send 0x11 then 0x22 -> data=0x11 and valid held; overrun
//    pulses at the 0x22 delivery. Raise ready in the same cycle as the 0x33
//    delivery -> data=0x33, no overrun.
// 5. Assert rst mid-DATA of 0x55 -> all outputs at reset values. Hold rx low
//    during and after reset -> no frame accepted until rx goes high.
//    A clean 0x55 afterwards is received.
// 6. Send back-to-back frames 0x00, 0xFF, 0x80 with no idle gap -> three valid
//    pulses with data in that order, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Constants and helpers shared by the UART transmit and receive stages.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    localparam int DEF_DATA_BITS = 8;
    localparam int FRAME_BITS    = DEF_DATA_BITS + 3;

    // Zero-extended payload: padding bits do not change the XOR.
    function automatic logic parity_bit(input logic [31:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Downstream byte handshake and status of the UART receiver.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 ready;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        input  ready,
        output data, valid, parity_err, frame_err, overrun, busy
    );

    modport slave (
        output ready,
        input  data, valid, parity_err, frame_err, overrun, busy
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ff <= {2{RST_VAL}};
        else     r_ff <= {r_ff[0], i_d};
    end

    assign o_q = r_ff[1];
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/parity/stop framing, error pulses,
// and a single-entry valid/ready output register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 w_tick;
    logic                 w_par_exp;

    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bad;
    logic                 r_armed;
    logic [1:0]           r_settle;
    logic                 r_deliver;
    logic                 r_perr;
    logic                 r_ferr;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ovr;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    assign w_tick    = (r_cnt == CNT_FULL);
    assign w_par_exp = parity_bit(32'(r_shift), 1'(PARITY_ODD));

    // r_settle holds off arming until the synchroniser carries real line
    // samples rather than its reset value, so a line held low stays unarmed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
            r_armed   <= 1'b0;
            r_settle  <= 2'b00;
            r_deliver <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_settle  <= {r_settle[0], 1'b1};
            r_deliver <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_cnt     <= r_cnt + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (r_settle[1] && w_rx_s) r_armed <= 1'b1;
                    if (r_armed && !w_rx_s)    r_state <= ST_START;
                end
                ST_START: if (r_cnt == CNT_HALF) begin
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_state <= w_rx_s ? ST_IDLE : ST_DATA;
                end
                ST_DATA: if (w_tick) begin
                    r_cnt   <= '0;
                    r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == IDX_LAST) r_state <= ST_PARITY;
                end
                ST_PARITY: if (w_tick) begin
                    r_cnt     <= '0;
                    r_par_bad <= (w_rx_s != w_par_exp);
                    r_state   <= ST_STOP;
                end
                ST_STOP: if (w_tick) begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_ferr  <= 1'b1;
                        r_state <= ST_BREAK;
                    end else begin
                        r_perr    <= r_par_bad;
                        r_deliver <= !r_par_bad;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_BREAK: begin
                    r_cnt <= '0;
                    if (w_rx_s) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (r_deliver) begin
                if (!r_valid || bus.ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && bus.ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.data       = r_data;
    assign bus.valid      = r_valid;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
    assign bus.overrun    = r_ovr;
    assign bus.busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame table plus corner-case sequences,
// received bytes checked against a scoreboard queue.
module tb_uart_rx;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_ODD(0)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_acc   = 0;
    int n_perr  = 0;
    int n_ferr  = 0;
    int n_ovr   = 0;
    int rise_cyc = -1;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every accepted byte is compared with the oldest expected one.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.parity_err) n_perr++;
            if (bus.frame_err)  n_ferr++;
            if (bus.overrun)    n_ovr++;
            if (bus.valid && !prev_valid) rise_cyc = cyc;
            if (bus.valid && bus.ready) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", bus.data);
                end else begin
                    check("rx_data", 32'(bus.data), 32'(exp_q.pop_front()));
                end
            end
        end
        prev_valid = bus.valid;
    end

    // Must be entered on a negedge; leaves on a negedge.
    task automatic send_frame(input logic [7:0] d, input bit pflip, input logic stopb);
        logic [10:0] f;
        f = {stopb, (^d) ^ pflip, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] d;
        bit         pflip;
        logic       stopb;
        int         e_acc;
        int         e_perr;
        int         e_ferr;
    } vec_t;

    vec_t vecs[6];
    int s_acc, s_perr, s_ferr, s_ovr, tf;

    task automatic snap();
        s_acc = n_acc; s_perr = n_perr; s_ferr = n_ferr; s_ovr = n_ovr;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1, 0, 0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 0, 1, 0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 0, 0, 1};
        vecs[3] = '{8'h3C, 1'b1, 1'b0, 0, 0, 1};
        vecs[4] = '{8'h5A, 1'b0, 1'b1, 1, 0, 0};
        vecs[5] = '{8'h07, 1'b1, 1'b1, 0, 1, 0};

        bus.ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data",  32'(bus.data), 0);
        check("rst_valid", 32'(bus.valid), 0);
        check("rst_busy",  32'(bus.busy), 0);
        check("rst_errs",  32'({bus.parity_err, bus.frame_err, bus.overrun}), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (8) @(negedge clk);

        // Single frame and latency from line fall to valid rise.
        snap();
        exp_q.push_back(8'hA5);
        tf = cyc + 1;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(32);
        check("lat_cycles", 32'(rise_cyc - tf), 2 + CPB/2 + 10*CPB + 1);
        check("lat_acc",    32'(n_acc - s_acc), 1);
        check("lat_errs",   32'(n_perr - s_perr + n_ferr - s_ferr), 0);

        for (int i = 0; i < 6; i++) begin
            snap();
            if (vecs[i].e_acc != 0) exp_q.push_back(vecs[i].d);
            send_frame(vecs[i].d, vecs[i].pflip, vecs[i].stopb);
            idle(64);
            check($sformatf("vec%0d_acc", i),  32'(n_acc - s_acc),   32'(vecs[i].e_acc));
            check($sformatf("vec%0d_perr", i), 32'(n_perr - s_perr), 32'(vecs[i].e_perr));
            check($sformatf("vec%0d_ferr", i), 32'(n_ferr - s_ferr), 32'(vecs[i].e_ferr));
            check($sformatf("vec%0d_busy", i), 32'(bus.busy), 0);
        end

        // Short low glitch is rejected at the mid-start check.
        snap();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_hi", 32'(bus.busy), 1);
        @(negedge clk);
        idle(30);
        check("glitch_busy_lo", 32'(bus.busy), 0);
        check("glitch_quiet", 32'(n_acc - s_acc + n_perr - s_perr + n_ferr - s_ferr), 0);

        // Line held low for 40 bits: one framing error, then a clean byte.
        snap();
        rx = 1'b0;
        repeat (40*CPB) @(negedge clk);
        idle(32);
        check("break_ferr", 32'(n_ferr - s_ferr), 1);
        check("break_perr", 32'(n_perr - s_perr), 0);
        check("break_busy", 32'(bus.busy), 0);
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b0, 1'b1);
        idle(32);
        check("break_rx01", 32'(n_acc - s_acc), 1);

        // Output register full: second byte overruns, third loads as ready rises.
        @(posedge clk); #1 bus.ready = 1'b0;
        @(negedge clk);
        snap();
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        idle(32);
        check("ovr_pulse", 32'(n_ovr - s_ovr), 1);
        check("ovr_valid", 32'(bus.valid), 1);
        check("ovr_data",  32'(bus.data), 32'h11);
        snap();
        exp_q.push_back(8'h33);
        fork
            send_frame(8'h33, 1'b0, 1'b1);
            begin
                repeat (2 + CPB/2 + 10*CPB + 1) @(posedge clk);
                #1 bus.ready = 1'b1;
            end
        join
        idle(32);
        check("same_cyc_ovr",  32'(n_ovr - s_ovr), 0);
        check("same_cyc_acc",  32'(n_acc - s_acc), 2);
        check("same_cyc_data", 32'(bus.data), 32'h33);

        // Reset in the middle of a frame, with the line held low through it.
        rx = 1'b0;
        repeat (CPB + 2*CPB + CPB/2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_data",  32'(bus.data), 0);
        check("mid_rst_valid", 32'(bus.valid), 0);
        check("mid_rst_busy",  32'(bus.busy), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        snap();
        repeat (100) @(negedge clk);
        check("held_low_busy",  32'(bus.busy), 0);
        check("held_low_quiet", 32'(n_acc - s_acc + n_ferr - s_ferr), 0);
        idle(20);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b0, 1'b1);
        idle(32);
        check("post_rst_rx55", 32'(n_acc - s_acc), 1);

        // Back-to-back frames with no idle gap.
        snap();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h80);
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h80, 1'b0, 1'b1);
        idle(64);
        check("b2b_acc",  32'(n_acc - s_acc), 3);
        check("b2b_errs", 32'(n_perr - s_perr + n_ferr - s_ferr + n_ovr - s_ovr), 0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
